// File: rtl/exec_trace_monitor.sv
// Execution monitor: counts PC changes and writebacks, shadows a register window, stops on limit or watchdog.
// Optional trace FIFO of captured writebacks when TRACE_FIFO_EN is defined.
module exec_trace_monitor #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16,
    parameter int REG_AW      = 4,
    parameter int TRACK_BASE  = 1,
    parameter int NUM_TRACK   = 2,
    parameter int INSTR_LIMIT = 4,
    parameter int TIMEOUT_CYC = 2000,
    parameter int CNT_W       = 16,
    parameter int TRACE_DEPTH = 8,
    localparam int SEL_W      = (NUM_TRACK > 1) ? $clog2(NUM_TRACK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [PC_W-1:0]   pc_value,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] shadow_q,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  wb_count,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [REG_AW-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_ovf
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [REG_AW:0]   WIN_LO  = (REG_AW + 1)'(TRACK_BASE);
    localparam logic [REG_AW:0]   WIN_HI  = (REG_AW + 1)'(TRACK_BASE + NUM_TRACK);
    localparam logic [REG_AW-1:0] BASE_A  = REG_AW'(TRACK_BASE);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_DONE, S_TIMEOUT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] shadow_reg_q [NUM_TRACK];
    logic [DATA_W-1:0] shadow_reg_d [NUM_TRACK];
    logic              wb_capture;
    logic              pc_change;
    logic [CNT_W-1:0]  pc_inc;
    logic [WD_W-1:0]   wd_inc;
    logic              in_win;
    logic [REG_AW-1:0] win_off;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pc_change = (pc_value != prev_pc_q);
    assign pc_inc    = sat_inc(instr_q);
    assign wd_inc    = wd_q + 1'b1;
    assign in_win    = ({1'b0, wb_addr} >= WIN_LO) && ({1'b0, wb_addr} < WIN_HI);
    assign win_off   = wb_addr - BASE_A;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        prev_pc_d    = prev_pc_q;
        instr_d      = instr_q;
        wb_cnt_d     = wb_cnt_q;
        wd_d         = wd_q;
        shadow_reg_d = shadow_reg_q;
        wb_capture   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (arm) begin
                    state_d   = S_RUN;
                    prev_pc_d = pc_value;
                    instr_d   = '0;
                    wb_cnt_d  = '0;
                    wd_d      = '0;
                    for (int i = 0; i < NUM_TRACK; i++) shadow_reg_d[i] = '0;
                end
            end
            S_RUN: begin
                wb_capture = wb_en;
                wd_d       = wd_inc;
                if (pc_change) begin
                    instr_d   = pc_inc;
                    prev_pc_d = pc_value;
                end
                // Limit takes priority over a watchdog expiring in the same cycle.
                if (pc_change && (pc_inc == CNT_W'(INSTR_LIMIT))) state_d = S_SETTLE;
                else if (wd_inc == WD_W'(TIMEOUT_CYC))            state_d = S_TIMEOUT;
            end
            S_SETTLE: begin
                wb_capture = wb_en;
                state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (wb_capture) begin
            wb_cnt_d = sat_inc(wb_cnt_q);
            for (int i = 0; i < NUM_TRACK; i++)
                if (in_win && (win_off == REG_AW'(i))) shadow_reg_d[i] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q   <= S_IDLE;
            prev_pc_q <= '0;
            instr_q   <= '0;
            wb_cnt_q  <= '0;
            wd_q      <= '0;
            // NOTE: shadows are reset because they are visible outputs; trace RAM is not, the count masks it.
            for (int i = 0; i < NUM_TRACK; i++) shadow_reg_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            prev_pc_q    <= prev_pc_d;
            instr_q      <= instr_d;
            wb_cnt_q     <= wb_cnt_d;
            wd_q         <= wd_d;
            shadow_reg_q <= shadow_reg_d;
        end
    end

    always_comb begin
        shadow_q = '0;
        for (int i = 0; i < NUM_TRACK; i++)
            if (rd_sel == SEL_W'(i)) shadow_q = shadow_reg_q[i];
    end

    assign instr_count = instr_q;
    assign wb_count    = wb_cnt_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_SETTLE);
    assign done        = (state_q == S_DONE);
    assign timeout     = (state_q == S_TIMEOUT);

`ifdef TRACE_FIFO_EN
    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    logic [REG_AW+DATA_W-1:0] fifo_mem [TRACE_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]           cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     full, pop, do_push;
    logic [REG_AW+DATA_W-1:0] head;

    assign full    = (cnt_q == (PTR_W + 1)'(TRACE_DEPTH));
    assign pop     = (cnt_q != '0) && trace_ready;
    assign do_push = wb_capture && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (wb_capture && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= {wb_addr, wb_data};
    end

    assign head        = fifo_mem[rd_ptr_q];
    assign trace_valid = (cnt_q != '0);
    assign trace_addr  = head[REG_AW+DATA_W-1:DATA_W];
    assign trace_data  = head[DATA_W-1:0];
    assign trace_ovf   = ovf_q;
`else
    localparam int UNUSED_DEPTH = TRACE_DEPTH;
    logic unused_trace_ready;
    assign unused_trace_ready = trace_ready;
    assign trace_valid = 1'b0;
    assign trace_addr  = '0;
    assign trace_data  = '0;
    assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_exec_trace_monitor.sv
// Self-checking bench for exec_trace_monitor: vector table with a scoreboard queue, then hand-written corner sequences.
module tb_exec_trace_monitor;

    localparam int TIMEOUT_CYC = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic [15:0] pc_value = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic [0:0]  rd_sel = '0;
    logic [15:0] shadow_q;
    logic [15:0] instr_count, wb_count;
    logic        busy, done, timeout;
    logic        trace_valid, trace_ovf;
    logic        trace_ready = 1'b0;
    logic [3:0]  trace_addr;
    logic [15:0] trace_data;

    int total = 0;
    int bad   = 0;

    exec_trace_monitor dut (
        .clk(clk), .rst(rst), .arm(arm), .pc_value(pc_value),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_sel(rd_sel),
        .shadow_q(shadow_q), .instr_count(instr_count), .wb_count(wb_count),
        .busy(busy), .done(done), .timeout(timeout),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_ovf(trace_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic [15:0] pc;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] e_ic;
        logic [15:0] e_wc;
        logic        e_busy;
        logic        e_done;
        logic        e_to;
        logic [15:0] e_s0;
        logic [15:0] e_s1;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input logic [15:0] pc, input logic we,
                                input logic [3:0] wa, input logic [15:0] wd,
                                input logic [15:0] ic, input logic [15:0] wc,
                                input logic b, input logic d, input logic t,
                                input logic [15:0] s0, input logic [15:0] s1);
        vec_t v;
        v.arm = a; v.pc = pc; v.we = we; v.wa = wa; v.wd = wd;
        v.e_ic = ic; v.e_wc = wc; v.e_busy = b; v.e_done = d; v.e_to = t;
        v.e_s0 = s0; v.e_s1 = s1;
        return v;
    endfunction

    task automatic drive(input logic a, input logic [15:0] pc, input logic we,
                         input logic [3:0] wa, input logic [15:0] wd);
        @(negedge clk);
        arm = a; pc_value = pc; wb_en = we; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_shadows(input string tag, input logic [15:0] s0, input logic [15:0] s1);
        rd_sel = 1'b0; #1;
        check({tag, " shadow0"}, 32'(shadow_q), 32'(s0));
        rd_sel = 1'b1; #1;
        check({tag, " shadow1"}, 32'(shadow_q), 32'(s1));
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        string tag;
        sb.push_back(v);
        drive(v.arm, v.pc, v.we, v.wa, v.wd);
        e = sb.pop_front();
        tag = $sformatf("v%0d", idx);
        check({tag, " instr_count"}, 32'(instr_count), 32'(e.e_ic));
        check({tag, " wb_count"},    32'(wb_count),    32'(e.e_wc));
        check({tag, " busy"},        32'(busy),        32'(e.e_busy));
        check({tag, " done"},        32'(done),        32'(e.e_done));
        check({tag, " timeout"},     32'(timeout),     32'(e.e_to));
        check_shadows(tag, e.e_s0, e.e_s1);
    endtask

    typedef struct { logic [3:0] a; logic [15:0] d; } tr_t;
    tr_t tq[$];

    initial begin
        // Basic run: baseline PC 0, four changes, two in-window writebacks.
        vecs.push_back(mk(1,  0, 0,  0, 16'h0000,  0, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  1, 1,  1, 16'h0005,  1, 1, 1, 0, 0, 16'h0005, 16'h0000));
        vecs.push_back(mk(0,  2, 0,  0, 16'h0000,  2, 1, 1, 0, 0, 16'h0005, 16'h0000));
        vecs.push_back(mk(0,  3, 1,  2, 16'h000A,  3, 2, 1, 0, 0, 16'h0005, 16'h000A));
        vecs.push_back(mk(0,  4, 0,  0, 16'h0000,  4, 2, 1, 0, 0, 16'h0005, 16'h000A));
        vecs.push_back(mk(0,  4, 0,  0, 16'h0000,  4, 2, 0, 1, 0, 16'h0005, 16'h000A));
        vecs.push_back(mk(0,  9, 1,  1, 16'h0077,  4, 2, 0, 1, 0, 16'h0005, 16'h000A));
        // Writeback trailing the final fetch is caught in SETTLE; one later is not.
        vecs.push_back(mk(1,  4, 0,  0, 16'h0000,  0, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  5, 0,  0, 16'h0000,  1, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  6, 0,  0, 16'h0000,  2, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  7, 0,  0, 16'h0000,  3, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  8, 0,  0, 16'h0000,  4, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  9, 1,  2, 16'h1234,  4, 1, 0, 1, 0, 16'h0000, 16'h1234));
        vecs.push_back(mk(0,  9, 1,  2, 16'h5555,  4, 1, 0, 1, 0, 16'h0000, 16'h1234));
        // Out-of-window addresses count only; arm during RUN is ignored; last same-address write wins.
        vecs.push_back(mk(1,  9, 0,  0, 16'h0000,  0, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1,  9, 1,  0, 16'hBEEF,  0, 1, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0,  9, 1, 15, 16'hBEEF,  0, 2, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1,  9, 1,  3, 16'hBEEF,  0, 3, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 10, 1,  1, 16'hBEEF,  1, 4, 1, 0, 0, 16'hBEEF, 16'h0000));
        vecs.push_back(mk(0, 10, 1,  1, 16'h0042,  1, 5, 1, 0, 0, 16'h0042, 16'h0000));
        vecs.push_back(mk(0, 10, 1,  1, 16'h0043,  1, 6, 1, 0, 0, 16'h0043, 16'h0000));

        rst = 1'b0;
        repeat (3) drive(0, 16'h0, 0, 0, 16'h0);
        check("reset instr_count", 32'(instr_count), 0);
        check("reset wb_count", 32'(wb_count), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset timeout", 32'(timeout), 0);
        check("reset trace_valid", 32'(trace_valid), 0);
        check("reset trace_ovf", 32'(trace_ovf), 0);
        check_shadows("reset", 16'h0, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset mid-run after a second PC change aborts everything.
        drive(0, 11, 0, 0, 16'h0);
        check("midrun instr_count", 32'(instr_count), 2);
        rst = 1'b0;
        drive(0, 12, 1, 1, 16'hDEAD);
        rst = 1'b1;
        check("rst instr_count", 32'(instr_count), 0);
        check("rst wb_count", 32'(wb_count), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst timeout", 32'(timeout), 0);
        check_shadows("rst", 16'h0, 16'h0);
        drive(0, 13, 1, 1, 16'h1111);
        drive(0, 14, 1, 2, 16'h2222);
        check("idle instr_count", 32'(instr_count), 0);
        check("idle wb_count", 32'(wb_count), 0);
        check("idle busy", 32'(busy), 0);
        check_shadows("idle", 16'h0, 16'h0);

        // Watchdog: constant PC for TIMEOUT_CYC RUN cycles.
        drive(1, 100, 0, 0, 16'h0);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) drive(0, 100, 0, 0, 16'h0);
        check("wd early timeout", 32'(timeout), 0);
        check("wd early busy", 32'(busy), 1);
        drive(0, 100, 0, 0, 16'h0);
        check("wd timeout", 32'(timeout), 1);
        check("wd done", 32'(done), 0);
        check("wd instr_count", 32'(instr_count), 0);
        check("wd busy", 32'(busy), 0);
        drive(0, 101, 1, 1, 16'h0999);
        check("wd hold instr", 32'(instr_count), 0);
        check("wd hold wb", 32'(wb_count), 0);
        drive(1, 100, 0, 0, 16'h0);
        check("rearm timeout", 32'(timeout), 0);
        check("rearm busy", 32'(busy), 1);
        for (int i = 1; i <= 4; i++) drive(0, 16'(100 + i), 0, 0, 16'h0);
        drive(0, 104, 0, 0, 16'h0);
        check("rearm done", 32'(done), 1);
        check("rearm instr_count", 32'(instr_count), 4);
        check("rearm timeout", 32'(timeout), 0);

        // Trace FIFO: nine writebacks into eight entries, nothing popped.
        rst = 1'b0;
        drive(0, 0, 0, 0, 16'h0);
        rst = 1'b1;
        drive(1, 200, 0, 0, 16'h0);
        trace_ready = 1'b0;
`ifdef TRACE_FIFO_EN
        begin
            logic exp_ovf;
            tr_t  e;
            exp_ovf = 1'b0;
            for (int i = 0; i < 9; i++) begin
                e.a = 4'(i + 1);
                e.d = 16'h0100 + 16'(i);
                if (tq.size() < 8) tq.push_back(e);
                else exp_ovf = 1'b1;
                drive(0, 200, 1, e.a, e.d);
            end
            check("fifo valid", 32'(trace_valid), 1);
            check("fifo ovf", 32'(trace_ovf), 32'(exp_ovf));
            for (int k = 0; k < 8; k++) begin
                if (tq.size() == 0) break;
                e = tq.pop_front();
                check($sformatf("fifo pop%0d valid", k), 32'(trace_valid), 1);
                check($sformatf("fifo pop%0d addr", k), 32'(trace_addr), 32'(e.a));
                check($sformatf("fifo pop%0d data", k), 32'(trace_data), 32'(e.d));
                trace_ready = 1'b1;
                drive(0, 200, 0, 0, 16'h0);
                trace_ready = 1'b0;
            end
            check("fifo empty", 32'(trace_valid), 0);
            check("fifo ovf sticky", 32'(trace_ovf), 1);
        end
`else
        trace_ready = 1'b1;
        for (int i = 0; i < 9; i++) drive(0, 200, 1, 4'(i + 1), 16'h0100 + 16'(i));
        check("notrace valid", 32'(trace_valid), 0);
        check("notrace ovf", 32'(trace_ovf), 0);
        check("notrace addr", 32'(trace_addr), 0);
        check("notrace data", 32'(trace_data), 0);
        check("notrace wb_count", 32'(wb_count), 9);
        trace_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_trace_monitor.md
Name: exec_trace_monitor

Overview:
- Synthesizable execution monitor for the multicycle CPU top. Snoops the PC and register-file writeback bus.
- Counts distinct PC changes and writebacks, and keeps shadow copies of a configurable window of registers.
- Stops at a configurable instruction limit or watchdog timeout, so checks that were bench-only run in RTL sim and on the board.

Parameters:
- DATA_W, 16, writeback data width
- PC_W, 16, PC width
- REG_AW, 4, register address width
- TRACK_BASE, 1, first tracked register index
- NUM_TRACK, 2, number of consecutive registers shadowed (TRACK_BASE+NUM_TRACK <= 2^REG_AW)
- INSTR_LIMIT, 4, PC changes after which the run completes (>=1)
- TIMEOUT_CYC, 2000, RUN cycles before watchdog fires (>=1)
- CNT_W, 16, counter width
- TRACE_DEPTH, 8, trace FIFO entries, power of two (TRACE_FIFO_EN only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- arm  in  1  start pulse; honoured only in IDLE, DONE, TIMEOUT
- pc_value  in  PC_W  current program counter
- wb_en  in  1  register-file write enable
- wb_addr  in  REG_AW  destination register
- wb_data  in  DATA_W  data written (ALU result or load data, muxed upstream)
- rd_sel  in  clog2(NUM_TRACK)  shadow register read select
- shadow_q  out  DATA_W  shadow[rd_sel], combinational read
- instr_count  out  CNT_W  PC changes seen this run
- wb_count  out  CNT_W  writebacks seen this run
- busy  out  1  high in RUN or SETTLE
- done  out  1  sticky; limit reached
- timeout  out  1  sticky; watchdog fired
- trace_valid  out  1  trace FIFO non-empty
- trace_ready  in  1  trace pop
- trace_addr  out  REG_AW  head entry register
- trace_data  out  DATA_W  head entry data
- trace_ovf  out  1  sticky; an entry was dropped

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all counters, shadows, done, timeout, busy, trace_ovf cleared to 0; FIFO emptied. Reset mid-run aborts with no residue.
- States: IDLE, RUN, SETTLE, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + arm: next cycle enters RUN.
  - prev_pc <= pc_value (baseline; baseline PC itself is not counted).
  - Counters, shadows, done, timeout, watchdog cleared.
  - FIFO and trace_ovf not cleared.
- arm in RUN/SETTLE: ignored.
- RUN, each cycle:
  - pc_value != prev_pc: instr_count+1, prev_pc <= pc_value.
  - wb_en: wb_count+1. If TRACK_BASE <= wb_addr < TRACK_BASE+NUM_TRACK, shadow[wb_addr-TRACK_BASE] <= wb_data. Out-of-window addresses are counted only.
  - Watchdog +1.
- RUN exits:
  - Incremented instr_count == INSTR_LIMIT: go to SETTLE.
  - Else watchdog reaches TIMEOUT_CYC: go to TIMEOUT, timeout=1.
  - Both in the same cycle: SETTLE wins.
- SETTLE: exactly one cycle. Writebacks are still captured (covers a WB that trails the final fetch). PC changes are ignored. Then DONE, done=1.
- DONE/TIMEOUT: wb_en and pc_value ignored; all outputs hold.
- Counters saturate at 2^CNT_W-1; no wrap.
- Same-address writebacks on consecutive cycles: last value wins.
- shadow_q and counters are valid at all times; reads do not disturb state.

Optional Feature:
- Macro TRACE_FIFO_EN.
- Defined:
  - Every captured writeback (RUN or SETTLE, any address) pushes {wb_addr, wb_data} into a TRACE_DEPTH FIFO.
  - Head is shown on trace_addr/trace_data with trace_valid.
  - Pop when trace_valid && trace_ready.
  - Push and pop in the same cycle while full: both succeed.
  - Push while full without pop: entry dropped, trace_ovf=1 (sticky until reset).
  - Pointers wrap modulo TRACE_DEPTH.
- Undefined: no FIFO logic; trace_valid=0, trace_addr=0, trace_data=0, trace_ovf=0; trace_ready ignored.

Test Plan:
- Reset then arm, PC 0->1->2->3->4, writebacks R1<=0x0005, R2<=0x000A -> instr_count=4, wb_count=2, shadow_q(sel0)=0x0005, shadow_q(sel1)=0x000A, done=1 one cycle after SETTLE, busy=0.
- wb_en R2<=0x1234 in the cycle after the 4th PC change -> captured in SETTLE, shadow[1]=0x1234. Same WB one cycle later -> ignored.
- Arm, PC held constant for TIMEOUT_CYC cycles -> timeout=1, done=0, instr_count=0. Arm again -> timeout clears, new run proceeds.
- Writeback to R0 and R15 with 0xBEEF -> wb_count increments, shadows unchanged. Arm pulse during RUN -> no effect.
- rst low mid-RUN after 2 PC changes -> next cycle: IDLE, all counters 0, done=timeout=0. PC changes without arm -> no counting.
- TRACE_FIFO_EN, TRACE_DEPTH=8, trace_ready=0, 9 writebacks -> trace_valid=1, trace_ovf=1. Pops return the first 8 entries in order; the 9th is absent.
